des_cbc_ctrl: RTL and testbench

Byte-stream mode controller upstream and downstream of the `des` core. It packs 8 input bytes into a 64-bit block and XORs the block with the chaining value in CBC mode. It then drives `des` through its `start`/`ready` handshake, captures `desOut`, updates the chaining value and serializes the ciphertext back out as bytes. It sits between the byte-wide datapath and the `des` core instance at the crypto top level.

---
 rtl/des_pkg.sv | 16 +
 rtl/des_byte_serializer.sv | 54 +++++
 rtl/des_cbc_ctrl.sv | 122 ++++++++++++
 tb/tb_des_cbc_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and sizes for the DES byte-stream mode controller.
package des_pkg;

  localparam int unsigned DES_BLK_W     = 64;
  localparam int unsigned DES_BLK_BYTES = 8;
  localparam int unsigned DES_CNT_W     = 3;
  localparam int unsigned DES_BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_EMIT    = 2'd3
  } des_cbc_state_t;

endpackage

// File: rtl/des_byte_serializer.sv
// Emits a captured 64-bit block as 8 bytes, MSB byte first, over valid/ready.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   load        capture data and start emitting (one cycle)
//   data        block to emit
//   out_ready   downstream accepts the current byte
//   out_valid   byte valid (registered)
//   out_data    current byte (registered)
//   done_c      last byte is being handed off this cycle
module des_byte_serializer
  import des_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DES_BLK_W-1:0]  data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DES_BYTE_W-1:0] out_data,
  output logic                  done_c
);

  logic [DES_BLK_W-1:0] shreg_q;
  logic [DES_CNT_W-1:0] cnt_q;
  logic                 fire_c;

  assign fire_c = out_valid && out_ready;
  assign done_c = fire_c && (cnt_q == DES_CNT_W'(DES_BLK_BYTES - 1));

  // Shift register: out_data always mirrors the top byte of what remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      shreg_q   <= data;
      cnt_q     <= '0;
      out_valid <= 1'b1;
      out_data  <= data[DES_BLK_W-1 -: DES_BYTE_W];
    end else if (done_c) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fire_c) begin
      shreg_q   <= {shreg_q[DES_BLK_W-DES_BYTE_W-1:0], DES_BYTE_W'(0)};
      cnt_q     <= cnt_q + DES_CNT_W'(1);
      out_data  <= shreg_q[DES_BLK_W-DES_BYTE_W-1 -: DES_BYTE_W];
    end
  end

endmodule

// File: rtl/des_cbc_ctrl.sv
// Byte-stream ECB/CBC controller around a peer des core.
// Packs 8 bytes into a block, optionally XORs with the chain value, runs the
// des start/ready handshake, then serializes the result back out as bytes.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   key, iv, iv_load              DES key; IV and its load strobe
//   in_valid/in_ready/in_data     input byte stream (first byte -> bits [1:8])
//   out_valid/out_ready/out_data  output byte stream
//   des_start/des_in/des_key      drive the des core
//   des_ready/des_out             des core result
//   busy                          low only when idle in COLLECT with no bytes
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter bit MODE_CBC = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:DES_BLK_W]    key,
  input  logic [1:DES_BLK_W]    iv,
  input  logic                  iv_load,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DES_BYTE_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DES_BYTE_W-1:0] out_data,
  output logic                  des_start,
  output logic [1:DES_BLK_W]    des_in,
  output logic [1:DES_BLK_W]    des_key,
  input  logic                  des_ready,
  input  logic [1:DES_BLK_W]    des_out,
  output logic                  busy
);

  localparam int unsigned PART_W = DES_BLK_W - DES_BYTE_W;

  des_cbc_state_t       state_q, state_d;
  logic [DES_CNT_W-1:0] count_q, count_d;
  // Only 7 bytes need storing; the 8th comes straight from in_data.
  logic [PART_W-1:0]    block_q;
  logic [DES_BLK_W-1:0] chain_q;
  logic [DES_BLK_W-1:0] block_next_c;
  logic                 accept_c, last_c, capture_c, iv_ok_c, done_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_COLLECT;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        accept_c = in_valid;
        if (in_valid && (count_q == DES_CNT_W'(DES_BLK_BYTES - 1))) begin
          last_c  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (des_ready) begin
          capture_c = 1'b1;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (done_c) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  assign iv_ok_c      = MODE_CBC && iv_load && (state_q == ST_COLLECT) && (count_q == '0);
  assign block_next_c = {block_q, in_data};
  // 3-bit count wraps to 0 on the 8th byte.
  assign count_d      = accept_c ? count_q + DES_CNT_W'(1) : count_q;

  // Block/chain/des registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      block_q   <= '0;
      chain_q   <= '0;
      des_start <= 1'b0;
      des_in    <= '0;
      des_key   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      count_q   <= count_d;
      des_start <= last_c;
      in_ready  <= (state_d == ST_COLLECT);
      busy      <= !((state_d == ST_COLLECT) && (count_d == '0));
      if (accept_c) block_q <= block_next_c[PART_W-1:0];
      if (capture_c && MODE_CBC) chain_q <= des_out;
      else if (iv_ok_c)          chain_q <= iv;
      if (last_c) begin
        des_in  <= MODE_CBC ? (block_next_c ^ chain_q) : block_next_c;
        des_key <= key;
      end
    end
  end

  des_byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (capture_c),
    .data      (des_out),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .done_c    (done_c)
  );

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Bench for des_cbc_ctrl: one CBC and one ECB instance share all stimulus.
// The des core is replaced by a stub cipher returning the known DES answer for
// the textbook vector and a fixed keyed scramble for anything else.
module tb_des_cbc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key = '0, iv = '0;
  logic        iv_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0, des_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic [63:0] des_out_c = '0, des_out_e = '0;

  logic        in_ready_c, out_valid_c, des_start_c, busy_c;
  logic        in_ready_e, out_valid_e, des_start_e, busy_e;
  logic [7:0]  out_data_c, out_data_e;
  logic [1:64] des_in_c, des_key_c, des_in_e, des_key_e;

  int checks = 0;
  int errors = 0;
  logic [63:0] chain_m = '0;

  always #5 clk = ~clk;

  des_cbc_ctrl #(.MODE_CBC(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .iv_load(iv_load),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .des_start(des_start_c), .des_in(des_in_c), .des_key(des_key_c),
    .des_ready(des_ready), .des_out(des_out_c), .busy(busy_c));

  des_cbc_ctrl #(.MODE_CBC(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .iv_load(iv_load),
    .in_valid(in_valid), .in_ready(in_ready_e), .in_data(in_data),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_data(out_data_e),
    .des_start(des_start_e), .des_in(des_in_e), .des_key(des_key_e),
    .des_ready(des_ready), .des_out(des_out_e), .busy(busy_e));

  function automatic logic [63:0] des_f(input logic [63:0] d, input logic [63:0] k);
    if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1) return 64'h85E813540F0AB405;
    return {d[40:0], d[63:41]} ^ k ^ 64'hA5A50F0F3C3C9696;
  endfunction

  // One block end to end; abort=1 resets both DUTs one cycle into WAIT.
  task automatic run_block(input logic [63:0] blk, input bit iv_first, input logic [63:0] ivv,
                           input bit iv_mid, input int gap_max, input int lat,
                           input bit stray, input int bp, input bit abort);
    logic [63:0] exp_in_c, exp_in_e, exp_o_c, exp_o_e, exp_key;
    int idx, cyc, g;
    bit rdy;
    for (int i = 0; i < 8; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        des_ready = stray && (j == 0);
        des_out_c = {$urandom, $urandom}; des_out_e = des_out_c;
        @(posedge clk); #1;
        des_ready = 1'b0;
        checks++;
        if ({in_ready_c, in_ready_e, des_start_c, des_start_e, out_valid_c, out_valid_e} !== 6'b110000) begin
          errors++;
          $display("FAIL gap_idle: got rdy=%b%b start=%b%b ov=%b%b want rdy=11 start=00 ov=00",
                   in_ready_c, in_ready_e, des_start_c, des_start_e, out_valid_c, out_valid_e);
        end
      end
      in_valid = 1'b1;
      in_data  = blk[63-8*i -: 8];
      iv_load  = (iv_first && i == 0) || (iv_mid && i == 3);
      iv       = (iv_first && i == 0) ? ivv : {$urandom, $urandom};
      if (iv_first && i == 0) chain_m = ivv;
      @(posedge clk); #1;
      in_valid = 1'b0; iv_load = 1'b0;
      if (i < 7) begin
        checks++;
        if ({in_ready_c, in_ready_e, des_start_c, des_start_e, busy_c, busy_e} !== 6'b110011) begin
          errors++;
          $display("FAIL collect_byte%0d: got rdy=%b%b start=%b%b busy=%b%b want rdy=11 start=00 busy=11",
                   i, in_ready_c, in_ready_e, des_start_c, des_start_e, busy_c, busy_e);
        end
      end
    end
    exp_in_c = blk ^ chain_m;
    exp_in_e = blk;
    exp_key  = key;
    checks++;
    if ({des_start_c, des_start_e, in_ready_c, in_ready_e, busy_c, busy_e} !== 6'b110011 ||
        des_in_c !== exp_in_c || des_in_e !== exp_in_e ||
        des_key_c !== exp_key || des_key_e !== exp_key) begin
      errors++;
      $display("FAIL start: got start=%b%b rdy=%b%b in_c=%h in_e=%h key=%h/%h want start=11 rdy=00 in_c=%h in_e=%h key=%h",
               des_start_c, des_start_e, in_ready_c, in_ready_e, des_in_c, des_in_e,
               des_key_c, des_key_e, exp_in_c, exp_in_e, exp_key);
    end
    key = {$urandom, $urandom};
    @(posedge clk); #1;
    checks++;
    if ({des_start_c, des_start_e} !== 2'b00) begin
      errors++;
      $display("FAIL start_pulse_width: got %b%b want 00", des_start_c, des_start_e);
    end
    if (abort) begin
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready_c, out_valid_c, out_data_c, des_start_c, des_in_c, des_key_c, busy_c} !== {1'b1, 1'b0, 8'h0, 1'b0, 64'h0, 64'h0, 1'b0} ||
          {in_ready_e, out_valid_e, out_data_e, des_start_e, des_in_e, des_key_e, busy_e} !== {1'b1, 1'b0, 8'h0, 1'b0, 64'h0, 64'h0, 1'b0}) begin
        errors++;
        $display("FAIL async_reset: got rdy=%b ov=%b od=%h st=%b in=%h key=%h busy=%b want reset values",
                 in_ready_c, out_valid_c, out_data_c, des_start_c, des_in_c, des_key_c, busy_c);
      end
      chain_m = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      des_ready = 1'b1; des_out_c = {$urandom, $urandom}; des_out_e = des_out_c;
      @(posedge clk); #1;
      des_ready = 1'b0;
      checks++;
      if ({out_valid_c, out_valid_e, in_ready_c, in_ready_e, busy_c, busy_e} !== 6'b001100) begin
        errors++;
        $display("FAIL late_ready_ignored: got ov=%b%b rdy=%b%b busy=%b%b want ov=00 rdy=11 busy=00",
                 out_valid_c, out_valid_e, in_ready_c, in_ready_e, busy_c, busy_e);
      end
      return;
    end
    repeat (lat - 1) begin @(posedge clk); #1; end
    checks++;
    if (des_in_c !== exp_in_c || des_in_e !== exp_in_e || des_key_c !== exp_key || des_key_e !== exp_key || out_valid_c !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold: got in_c=%h in_e=%h key=%h ov=%b want in_c=%h in_e=%h key=%h ov=0",
               des_in_c, des_in_e, des_key_c, out_valid_c, exp_in_c, exp_in_e, exp_key);
    end
    exp_o_c = des_f(exp_in_c, exp_key);
    exp_o_e = des_f(exp_in_e, exp_key);
    chain_m = exp_o_c;
    des_ready = 1'b1; des_out_c = exp_o_c; des_out_e = exp_o_e;
    @(posedge clk); #1;
    des_ready = 1'b0; des_out_c = {$urandom, $urandom}; des_out_e = {$urandom, $urandom};
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 64) begin
      checks++;
      if (out_valid_c !== 1'b1 || out_valid_e !== 1'b1 || in_ready_c !== 1'b0 || in_ready_e !== 1'b0 ||
          out_data_c !== exp_o_c[63-8*idx -: 8] || out_data_e !== exp_o_e[63-8*idx -: 8]) begin
        errors++;
        $display("FAIL emit_byte%0d: got ov=%b%b rdy=%b%b data=%h/%h want ov=11 rdy=00 data=%h/%h",
                 idx, out_valid_c, out_valid_e, in_ready_c, in_ready_e, out_data_c, out_data_e,
                 exp_o_c[63-8*idx -: 8], exp_o_e[63-8*idx -: 8]);
      end
      rdy = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1, 0));
      out_ready = rdy;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    checks++;
    if (idx < 8) begin
      errors++;
      $display("FAIL emit_timeout: got %0d bytes want 8", idx);
    end
    checks++;
    if ({out_valid_c, out_valid_e, in_ready_c, in_ready_e, busy_c, busy_e} !== 6'b001100) begin
      errors++;
      $display("FAIL return_collect: got ov=%b%b rdy=%b%b busy=%b%b want ov=00 rdy=11 busy=00",
               out_valid_c, out_valid_e, in_ready_c, in_ready_e, busy_c, busy_e);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready_c, out_valid_c, out_data_c, des_start_c, des_in_c, des_key_c, busy_c} !== {1'b1, 1'b0, 8'h0, 1'b0, 64'h0, 64'h0, 1'b0} ||
        {in_ready_e, out_valid_e, out_data_e, des_start_e, des_in_e, des_key_e, busy_e} !== {1'b1, 1'b0, 8'h0, 1'b0, 64'h0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b ov=%b od=%h st=%b in=%h key=%h busy=%b want 1 0 00 0 0 0 0",
               in_ready_c, out_valid_c, out_data_c, des_start_c, des_in_c, des_key_c, busy_c);
    end
    rst_n = 1'b1;
    chain_m = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_ecb_vector;
    key = 64'h133457799BBCDFF1;
    run_block(64'h0123456789ABCDEF, 1'b0, '0, 1'b0, 0, 3, 1'b0, 0, 1'b0);
  endtask

  task automatic test_cbc_chain;
    checks++;
    if (chain_m !== 64'h85E813540F0AB405) begin
      errors++;
      $display("FAIL cbc_first_cipher: got %h want 85e813540f0ab405", chain_m);
    end
    key = 64'h133457799BBCDFF1;
    run_block(64'h0, 1'b0, '0, 1'b0, 0, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_iv_load;
    key = 64'h133457799BBCDFF1;
    run_block(64'h0123456789ABCDEF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 4, 1'b0, 0, 1'b0);
    run_block({$urandom, $urandom}, 1'b0, '0, 1'b1, 0, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_block({$urandom, $urandom}, 1'b0, '0, 1'b0, 0, 5, 1'b0, 1, 1'b0);
  endtask

  task automatic test_stalls;
    run_block({$urandom, $urandom}, 1'b0, '0, 1'b0, 3, 1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait;
    run_block({$urandom, $urandom}, 1'b0, '0, 1'b0, 0, 3, 1'b0, 0, 1'b1);
    run_block({$urandom, $urandom}, 1'b0, '0, 1'b0, 0, 2, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int b = 0; b < 6; b++) begin
      key = {$urandom, $urandom};
      run_block({$urandom, $urandom}, 1'($urandom_range(1, 0)), {$urandom, $urandom}, 1'($urandom_range(1, 0)),
                int'($urandom_range(2, 0)), int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)), 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_ecb_vector();
    test_cbc_chain();
    test_iv_load();
    test_backpressure();
    test_stalls();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
